matrix_operand_fetch: RTL and testbench

//  Upstream feeder for the pipelined matrix control unit. On start, walks an NxN matrix pair
//  (N=2..5) stored row-major in two synchronous element RAMs (A, B). Emits one operand pair per

---
 rtl/matrix_operand_fetch.sv | 160 ++++++++++++++++
 tb/tb_matrix_operand_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_fetch.sv
// matrix_operand_fetch
//   Walks an NxN operand pair (N = matrix_size + 2) held row-major in two synchronous element
//   RAMs and streams one {A, B} pair per element on a valid/ready interface. A 2-entry FIFO
//   absorbs the 1-cycle RAM read latency, so backpressure never drops a pair.
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, op_code,
//   matrix_size              fetch request; op_code/size latched when start is accepted in IDLE
//   mem_rd_en, mem_addr      shared read strobe/address for RAM A and RAM B
//   mem_data_a, mem_data_b   RAM read data, valid the cycle after mem_rd_en
//   out_valid, out_ready     output handshake, transfer = out_valid & out_ready
//   out_op_code, out_size    latched request fields
//   out_operand1/2           element of A / element of B
//   out_index, out_last      linear index r*N+c and last-element flag of the FIFO head
//   busy, done               FETCH/DRAIN indicator, 1-cycle pulse after the last transfer
module matrix_operand_fetch #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_code,
  input  logic [1:0]        matrix_size,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_a,
  input  logic [DATA_W-1:0] mem_data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_op_code,
  output logic [1:0]        out_size,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [4:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(MAX_DIM);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [1:0]        size_q;
  logic [2:0]        row_q, col_q;
  logic [4:0]        idx_q;

  // Read in flight: its index/last travel alongside the RAM latency.
  logic              inflight_q;
  logic [4:0]        infl_idx_q;
  logic              infl_last_q;

  logic [DATA_W-1:0] fa_q [2];
  logic [DATA_W-1:0] fb_q [2];
  logic [4:0]        fi_q [2];
  logic              fl_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  logic [2:0]        nm1;
  logic              last_issue;
  logic              pop_now;
  logic              credit;

  assign nm1        = {1'b0, size_q} + 3'd1;
  assign last_issue = (row_q == nm1) && (col_q == nm1);
  assign pop_now    = out_valid & out_ready;
  // fifo_count + inflight - pop_now < 2, rearranged to avoid unsigned underflow.
  assign credit     = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_now});

  assign mem_rd_en  = (state_q == StFetch) && credit;
  assign mem_addr   = mem_rd_en ? (ADDR_W'(row_q) * Stride + ADDR_W'(col_q)) : '0;

  assign out_valid    = (count_q != 2'd0);
  assign out_operand1 = out_valid ? fa_q[rd_ptr_q] : '0;
  assign out_operand2 = out_valid ? fb_q[rd_ptr_q] : '0;
  assign out_index    = out_valid ? fi_q[rd_ptr_q] : '0;
  assign out_last     = out_valid ? fl_q[rd_ptr_q] : 1'b0;
  assign out_op_code  = op_q;
  assign out_size     = size_q;
  assign busy         = (state_q == StFetch) || (state_q == StDrain);
  assign done         = (state_q == StDone);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      size_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        fa_q[i] <= '0;
        fb_q[i] <= '0;
        fi_q[i] <= '0;
        fl_q[i] <= 1'b0;
      end
    end else begin
      inflight_q <= mem_rd_en;
      if (mem_rd_en) begin
        infl_idx_q  <= idx_q;
        infl_last_q <= last_issue;
      end

      // The credit rule guarantees a push never lands in a full FIFO.
      if (inflight_q) begin
        fa_q[wr_ptr_q] <= mem_data_a;
        fb_q[wr_ptr_q] <= mem_data_b;
        fi_q[wr_ptr_q] <= infl_idx_q;
        fl_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop_now) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop_now};

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            op_q    <= op_code;
            size_q  <= matrix_size;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
          end
        end
        StFetch: begin
          if (mem_rd_en) begin
            idx_q <= idx_q + 5'd1;
            if (col_q == nm1) begin
              col_q <= '0;
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_q + 3'd1;
            end
            if (last_issue) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop_now && out_last) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_fetch.sv
module tb_matrix_operand_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_code;
  logic [1:0] matrix_size;
  logic       mem_rd_en;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_a;
  logic [7:0] mem_data_b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op_code;
  logic [1:0] out_size;
  logic [7:0] out_operand1;
  logic [7:0] out_operand2;
  logic [4:0] out_index;
  logic       out_last;
  logic       busy;
  logic       done;

  matrix_operand_fetch #(.DATA_W(8), .MAX_DIM(5), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_code      (op_code),
    .matrix_size  (matrix_size),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_data_a   (mem_data_a),
    .mem_data_b   (mem_data_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op_code  (out_op_code),
    .out_size     (out_size),
    .out_operand1 (out_operand1),
    .out_operand2 (out_operand2),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] size;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] idx;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         addr_q[$];
  logic [7:0] ram_a [25];
  logic [7:0] ram_b [25];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int outstanding;
  int xfer_cnt;
  int done_cnt;
  int first_valid_cyc;
  int first_xfer_cyc;
  int last_xfer_cyc;
  int done_cyc;
  logic        stall_prev;
  logic        last_prev;
  logic [23:0] prev_head;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous-read RAM models.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data_a <= ram_a[mem_addr];
      mem_data_b <= ram_b[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic xfer;
    exp_t e;
    int   ea;
    if (rst) begin
      xfer = out_valid && out_ready;
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          check_eq("extra_read", 32'd1, 32'd0);
        end else begin
          ea = addr_q.pop_front();
          check_eq("mem_addr", 32'(mem_addr), 32'(ea));
        end
        check_eq("credit", 32'((outstanding - int'(xfer)) < 2), 32'd1);
      end
      if (stall_prev)
        check_eq("head_stable", 32'({out_operand1, out_operand2, out_index, out_last, 2'b00}),
                 32'(prev_head));
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("operand1", 32'(out_operand1), 32'(e.a));
          check_eq("operand2", 32'(out_operand2), 32'(e.b));
          check_eq("index", 32'(out_index), 32'(e.idx));
          check_eq("last", 32'(out_last), 32'(e.last));
          check_eq("op_code", 32'(out_op_code), 32'(e.op));
          check_eq("size", 32'(out_size), 32'(e.size));
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (done || last_prev) check_eq("done_pulse", 32'(done), 32'(last_prev));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      last_prev   = xfer && out_last;
      stall_prev  = out_valid && !out_ready;
      prev_head   = {out_operand1, out_operand2, out_index, out_last, 2'b00};
      outstanding = outstanding + int'(mem_rd_en) - int'(xfer);
    end
  end

  task automatic clear_model();
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    stall_prev  = 1'b0;
    last_prev   = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles then high.
  // abort_after > 0 stops driving after that many transfers (used before a reset).
  task automatic run_fetch(input logic [2:0] op, input logic [1:0] sz, input int mode,
                           input int abort_after, input bit spurious, output int start_cyc);
    int   n;
    int   r;
    int   c;
    exp_t e;
    n = int'(sz) + 2;
    for (int i = 0; i < n * n; i++) begin
      r = i / n;
      c = i % n;
      addr_q.push_back(r * 5 + c);
      e.op   = op;
      e.size = sz;
      e.a    = ram_a[r * 5 + c];
      e.b    = ram_b[r * 5 + c];
      e.idx  = 5'(i);
      e.last = (i == n * n - 1);
      exp_q.push_back(e);
    end
    done_cnt        = 0;
    xfer_cnt        = 0;
    first_valid_cyc = -1;
    start           = 1'b1;
    op_code         = op;
    matrix_size     = sz;
    out_ready       = (mode != 2);
    start_cyc       = cyc;
    @(posedge clk); #1;
    start       = 1'b0;
    op_code     = ~op;
    matrix_size = sz + 2'd1;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 300; k++) begin
      if (done_cnt > 0) break;
      if (abort_after > 0 && xfer_cnt >= abort_after) break;
      if (mode == 2 && k == 8) begin
        check_eq("stall_no_read", 32'(mem_rd_en), 32'd0);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_outstanding", 32'(outstanding), 32'd2);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 10);
      endcase
      start = (spurious && k == 4);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (abort_after == 0) begin
      if (done_cnt == 0) check_eq("timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("xfer_count", 32'(xfer_cnt), 32'(n * n));
      check_eq("exp_left", 32'(exp_q.size()), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int sc;
    for (int i = 0; i < 25; i++) begin
      ram_a[i] = 8'hEE;
      ram_b[i] = 8'hDD;
    end
    rst         = 1'b0;
    start       = 1'b0;
    op_code     = '0;
    matrix_size = '0;
    out_ready   = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fields", 32'({out_op_code, out_size, out_index, out_last}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 2x2: A = 1..4, B = 10..40 at row stride 5.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ram_a[r * 5 + c] = 8'(r * 2 + c + 1);
        ram_b[r * 5 + c] = 8'((r * 2 + c + 1) * 10);
      end
    run_fetch(3'd1, 2'd0, 0, 0, 1'b0, sc);

    // 5x5 full-throughput timing.
    for (int i = 0; i < 25; i++) begin
      ram_a[i] = 8'(i + 1);
      ram_b[i] = 8'(200 - i);
    end
    run_fetch(3'd5, 2'd3, 0, 0, 1'b0, sc);
    check_eq("first_valid_lat", 32'(first_valid_cyc - sc), 32'd3);
    check_eq("back_to_back", 32'(last_xfer_cyc - first_xfer_cyc), 32'd24);
    check_eq("done_cycle", 32'(done_cyc - sc), 32'd28);

    // 3x3 with random backpressure.
    for (int i = 0; i < 25; i++) begin
      ram_a[i] = 8'($urandom_range(0, 255));
      ram_b[i] = 8'($urandom_range(0, 255));
    end
    run_fetch(3'd2, 2'd1, 1, 0, 1'b0, sc);

    // 4x4 with a stray start mid-fetch.
    run_fetch(3'd6, 2'd2, 0, 0, 1'b1, sc);

    // Reset after five transfers of a 5x5 fetch.
    run_fetch(3'd3, 2'd3, 0, 5, 1'b0, sc);
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_fields",
             32'({out_op_code, out_size, out_index, out_last, out_operand1, out_operand2}), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_fetch(3'd4, 2'd0, 0, 0, 1'b0, sc);

    // 2x2 with the consumer stalled from the start.
    run_fetch(3'd7, 2'd0, 2, 0, 1'b0, sc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
